// File: rtl/password_lock_n.sv
// password_lock_n: switch-entry password lock with press edge detection, failed-attempt
// lockout and run-time reprogramming, driving LEDs and five active-low 7-seg digits.
module password_lock_n #(
    parameter int                                   SW_W        = 10,
    parameter int                                   CODE_LEN    = 4,
    parameter int                                   IDX_W       = $clog2(SW_W),
    parameter logic [CODE_LEN*IDX_W-1:0]            CODE        = 16'h5173,
    parameter int                                   MAX_TRIES   = 3,
    parameter int                                   LOCK_CYCLES = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] switches,
    input  logic            prog,
    output logic [SW_W-1:0] led_out,
    output logic [6:0]      HEX0,
    output logic [6:0]      HEX1,
    output logic [6:0]      HEX2,
    output logic [6:0]      HEX3,
    output logic [6:0]      HEX4,
    output logic            unlocked,
    output logic            locked_out
);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int KW = CODE_LEN * IDX_W;
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_LOCK, S_DONE, S_PROG} state_t;

    logic [SW_W-1:0] sw_m_q, sw_s_q, sw_d_q;
    logic            prog_m_q, prog_s_q;
    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d, pcnt_q, pcnt_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [KW-1:0]   code_q, code_d, new_q, new_d;
    logic            press, onehot;
    logic [IDX_W-1:0] dig;

    // Sync flops reset to ones so a switch held through reset is not seen as a press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_m_q   <= '1;
            sw_s_q   <= '1;
            sw_d_q   <= '1;
            prog_m_q <= 1'b1;
            prog_s_q <= 1'b1;
        end else begin
            sw_m_q   <= switches;
            sw_s_q   <= sw_m_q;
            sw_d_q   <= sw_s_q;
            prog_m_q <= prog;
            prog_s_q <= prog_m_q;
        end
    end

    assign press  = (|sw_s_q) && !(|sw_d_q);
    assign onehot = (|sw_s_q) && ((sw_s_q & (sw_s_q - SW_W'(1))) == '0);

    always_comb begin
        dig = '0;
        for (int i = 0; i < SW_W; i++)
            if (sw_s_q[i]) dig = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pcnt_q  <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            code_q  <= CODE;
            new_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            new_q   <= new_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        code_d  = code_q;
        new_d   = new_q;
        case (state_q)
            S_IDLE: begin
                if (press && onehot && dig == code_q[idx_q*IDX_W +: IDX_W]) begin
                    idx_d = idx_q + CW'(1);
                    if (idx_q == CW'(CODE_LEN - 1)) begin
                        idx_d   = '0;
                        fail_d  = '0;
                        state_d = S_DONE;
                    end
                end else if (press) begin
                    idx_d   = '0;
                    fail_d  = (fail_q == FW'(MAX_TRIES)) ? fail_q : fail_q + FW'(1);
                    state_d = (fail_d == FW'(MAX_TRIES)) ? S_LOCK : S_ERR;
                end
            end
            S_ERR: begin
                if (press) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(LOCK_CYCLES - 1)) begin
                    timer_d = '0;
                    fail_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (prog_s_q) begin
                    pcnt_d  = '0;
                    state_d = S_PROG;
                end else if (press) begin
                    state_d = S_IDLE;
                end
            end
            S_PROG: begin
                if (!prog_s_q || (press && !onehot)) begin
                    state_d = S_DONE;
                end else if (press) begin
                    new_d[pcnt_q*IDX_W +: IDX_W] = dig;
                    pcnt_d = pcnt_q + CW'(1);
                    if (pcnt_q == CW'(CODE_LEN - 1)) begin
                        code_d  = new_d;
                        pcnt_d  = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        led_out    = '0;
        {HEX4, HEX3, HEX2, HEX1, HEX0} = {5{BLANK}};
        unlocked   = (state_q == S_DONE) || (state_q == S_PROG);
        locked_out = (state_q == S_LOCK);
        case (state_q)
            S_IDLE: led_out = (SW_W'(1) << idx_q) - SW_W'(1);
            S_DONE: begin
                led_out = SW_W'((1 << CODE_LEN) - 1);
                {HEX3, HEX2, HEX1, HEX0} = {7'h21, 7'h40, 7'h48, 7'h06};
            end
            S_ERR: {HEX4, HEX3, HEX2, HEX1, HEX0} = {7'h06, 7'h2F, 7'h2F, 7'h23, 7'h2F};
            S_LOCK: begin
                led_out = '1;
                {HEX3, HEX2, HEX1} = {7'h47, 7'h40, 7'h46};
            end
            S_PROG: begin
                led_out = ((SW_W'(1) << pcnt_q) - SW_W'(1)) | (SW_W'(1) << (SW_W - 1));
                {HEX3, HEX2, HEX1, HEX0} = {7'h0C, 7'h2F, 7'h23, 7'h42};
            end
            default: led_out = '0;
        endcase
    end
endmodule
